seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receiving end of the multiplexed 7-segment scan interface. Samples the active-low digit-select (`sm_wei`) and segment (`sm_duan`) buses produced by the board's scanned-display driver and reconstructs the 8-bit value being shown. The low nibble is taken from digit 0 and the high nibble from digit 1. Used for loopback self-check on board and as a bus monitor in system simulation.

## Interface
- `SETTLE_CYCLES`, default 16: clk cycles a digit select must be held stable before its segments are sampled; legal range 2..65535.
- `CONFIRM_SCANS`, default 2: number of consecutive identical complete frames required before `data` updates; legal range 1..15.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sm_wei`  in  4  digit select, active-low one-hot; bit0 = digit 0 (low nibble), bit1 = digit 1 (high nibble).
- `sm_duan`  in  8  segments, active-low; bit7 = dp, bits6:0 = g..a.
- `data`  out  8  last confirmed displayed value.
- `data_valid`  out  1  one-cycle pulse when `data` is loaded.
- `data_stable`  out  1  level; high while the confirmed value continues to match incoming frames.
- `frame_err`  out  1  one-cycle pulse on a protocol violation.

## Operation
- Input sync: both buses pass through two flops. Reset values are `sm_wei` sync = 4'hF and `sm_duan` sync = 8'hFF. All logic below uses the synced values.
- Dwell counter (16 bit, saturating) clears whenever synced `wei` differs from its previous-cycle value, and increments otherwise.
- Sample event: fires in the one cycle where the counter equals SETTLE_CYCLES-1, so there is at most one sample per dwell. A dwell shorter than SETTLE_CYCLES produces no sample and is not an error.
- `wei` classes:
  - 1110 = digit 0.
  - 1101 = digit 1.
  - 1011 and 0111 = legal digits that are ignored.
  - 1111 = blank, ignored.
  - Any other value is illegal and raises an error at its sample event.
- Segment decode (dp must be 1, i.e. off):
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0
  - 4 = 99, 5 = 92, 6 = 82, 7 = F8
  - 8 = 80, 9 = 90, A = 88, B = 83
  - C = C6, D = A1, E = 86, F = 8E
  - Any other byte at a digit 0/1 sample is an error.
- FSM states:
  - IDLE: a digit-0 sample stores `lo` and moves to GOT_LO. Digit-1 samples are ignored.
  - GOT_LO: a digit-0 sample overwrites `lo` and stays. A digit-1 sample stores `hi`, completes the frame {hi,lo}, and returns to IDLE.
- Frame completion:
  - If {hi,lo} equals `cand`, `match` increments, saturating at CONFIRM_SCANS. Otherwise `cand` <= {hi,lo} and `match` <= 1.
  - When `match` reaches CONFIRM_SCANS and `cand` differs from `data`, or no lock has occurred since reset: load `data`, pulse `data_valid`, set `data_stable`.
  - A completed frame that differs from `data` clears `data_stable`.
- Error handling: pulse `frame_err`, FSM to IDLE, `match` <= 0, clear `data_stable`. `data` is retained.
- Precedence: reset > error > frame completion.

## Timing
- Reset values: `data` = 8'h00, `data_valid` = 0, `data_stable` = 0, `frame_err` = 0, FSM = IDLE, `match` = 0, `cand` = 0, dwell = 0, lock flag = 0.
- Pin-to-sample latency: 2 sync cycles + SETTLE_CYCLES-1 cycles of dwell.
- Outputs are registered. `data`, `data_valid`, and `data_stable` change on the edge after the digit-1 sample cycle that completes the confirming frame. `frame_err` asserts on the edge after the offending sample.
- `data_valid` and `frame_err` last exactly one cycle per event and never assert in the same cycle.
- Reset mid-frame discards `lo`, `cand`, and `match`. A fresh CONFIRM_SCANS frames are then required before the first `data_valid`.
- A repeated value after lock produces no `data_valid` pulse.

## Test plan
All scenarios use SETTLE_CYCLES=16, CONFIRM_SCANS=2, and a 200-cycle dwell per digit unless noted.
- Drive 8'hA5 (digit 0 = 92, digit 1 = 88) -> exactly one `data_valid` after the 2nd frame; `data` = A5; `data_stable` = 1; no further pulses over 10 frames.
- Switch the display from A5 to 3C -> `data_stable` falls at the first 3C frame; after the 2nd 3C frame, `data` = 3C with one `data_valid` pulse.
- Digit 0 shows segment byte FF (or dp = 0, e.g. 40) -> `frame_err` pulse, `data_stable` = 0, `data` holds A5; two clean frames then re-lock.
- `wei` = 1100 held 200 cycles -> one `frame_err` pulse. Then shorten a digit-0 dwell to 5 cycles -> no sample, no error, no loss of lock.
- Assert `rst` after a digit-0 sample of frame 1 -> all outputs at reset values next cycle; `data_valid` occurs only after 2 complete post-reset frames.
- Set CONFIRM_SCANS=1, drive 00, then FF -> `data_valid` after each single frame; `data` = 00, then FF.

Source files
------------

// File: rtl/seg_scan_decoder_if.sv
// Scan-bus bundle between a scanned 7-segment driver and its decoder.
// The driver side (master) owns the digit/segment pins; the decoder side
// (slave) owns the reconstructed value and its status strobes.
interface seg_scan_decoder_if;
    logic [3:0] sm_wei;       // digit select, active-low one-hot
    logic [7:0] sm_duan;      // segments, active-low, bit7 = dp
    logic [7:0] data;         // last confirmed displayed value
    logic       data_valid;   // one-cycle pulse when data loads
    logic       data_stable;  // confirmed value still matches frames
    logic       frame_err;    // one-cycle pulse on protocol violation

    modport master (
        output sm_wei,
        output sm_duan,
        input  data,
        input  data_valid,
        input  data_stable,
        input  frame_err
    );

    modport slave (
        input  sm_wei,
        input  sm_duan,
        output data,
        output data_valid,
        output data_stable,
        output frame_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Receiving end of a multiplexed 7-segment scan bus. Watches the digit
// select and segment lines, samples each digit once it has settled, and
// rebuilds the 8-bit value shown on digits 0 (low nibble) and 1 (high
// nibble). A value is only reported after CONFIRM_SCANS identical frames.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CONFIRM_SCANS = 2
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_decoder_if.slave bus
);

    // Frame assembly FSM
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_GOT_LO = 1'b1;

    // Counter value at which the settled digit is sampled
    localparam logic [15:0] SAMPLE_AT = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  CONFIRM_N = 4'(CONFIRM_SCANS);
    localparam logic [15:0] DWELL_MAX = 16'hFFFF;

    // Active-low segment patterns for hex digits 0..F (dp off on all)
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Digit-select codes
    localparam logic [3:0] WEI_D0    = 4'b1110;
    localparam logic [3:0] WEI_D1    = 4'b1101;
    localparam logic [3:0] WEI_D2    = 4'b1011;
    localparam logic [3:0] WEI_D3    = 4'b0111;
    localparam logic [3:0] WEI_BLANK = 4'b1111;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [3:0] wei_s1_q;
    logic [3:0] wei_s2_q;
    logic [7:0] duan_s1_q;
    logic [7:0] duan_s2_q;

    // Two-flop synchronisers; reset to "all segments/digits off"
    always_ff @(posedge clk) begin
        if (rst) begin
            wei_s1_q  <= 4'hF;
            wei_s2_q  <= 4'hF;
            duan_s1_q <= 8'hFF;
            duan_s2_q <= 8'hFF;
        end else begin
            wei_s1_q  <= bus.sm_wei;
            wei_s2_q  <= wei_s1_q;
            duan_s1_q <= bus.sm_duan;
            duan_s2_q <= duan_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Dwell counter and sample strobe
    // ------------------------------------------------------------------
    logic [3:0]  wei_prev_q;
    logic [15:0] dwell_q;
    logic [15:0] dwell_d;
    logic        sample;

    // Count of cycles the current select has been held; restarts on change
    always_comb begin
        if (wei_s2_q != wei_prev_q) begin
            dwell_d = 16'd0;
        end else if (dwell_q != DWELL_MAX) begin
            dwell_d = dwell_q + 16'd1;
        end else begin
            dwell_d = dwell_q;
        end
    end

    // Exactly one sample per dwell, only when the dwell is long enough
    assign sample = (dwell_d == SAMPLE_AT);

    // Remember last select and the running dwell count
    always_ff @(posedge clk) begin
        if (rst) begin
            wei_prev_q <= 4'hF;
            dwell_q    <= 16'd0;
        end else begin
            wei_prev_q <= wei_s2_q;
            dwell_q    <= dwell_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit-select classification
    // ------------------------------------------------------------------
    logic is_d0;
    logic is_d1;
    logic is_ignored;

    // Split the select into digit 0, digit 1, ignored and illegal codes
    always_comb begin
        is_d0      = 1'b0;
        is_d1      = 1'b0;
        is_ignored = 1'b0;
        case (wei_s2_q)
            WEI_D0:                      is_d0      = 1'b1;
            WEI_D1:                      is_d1      = 1'b1;
            WEI_D2, WEI_D3, WEI_BLANK:   is_ignored = 1'b1;
            default:                     ;
        endcase
    end

    // ------------------------------------------------------------------
    // Segment decode: one comparator per hex glyph
    // ------------------------------------------------------------------
    logic [15:0] seg_hit;
    logic        seg_ok;
    logic [3:0]  seg_nib;

    for (genvar gi = 0; gi < 16; gi++) begin : g_seg_match
        assign seg_hit[gi] = (duan_s2_q == SEG_TABLE[gi]);
    end

    assign seg_ok = |seg_hit;

    // Encode the matching glyph back to its nibble (hits are mutually exclusive)
    always_comb begin
        seg_nib = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_hit[i]) begin
                seg_nib = 4'(i);
            end
        end
    end

    // A sampled digit is bad if its select is illegal, or if it is digit
    // 0/1 and the segment byte is not a recognised glyph.
    logic sample_err;
    assign sample_err = sample &&
                        ((is_d0 || is_d1) ? !seg_ok : !is_ignored);

    // ------------------------------------------------------------------
    // Frame assembly, confirmation and output state
    // ------------------------------------------------------------------
    logic [0:0] state_q,  state_d;
    logic [3:0] lo_q,     lo_d;
    logic [7:0] cand_q,   cand_d;
    logic [3:0] match_q,  match_d;
    logic [7:0] data_q,   data_d;
    logic       locked_q, locked_d;
    logic       stable_q, stable_d;
    logic       valid_q,  valid_d;
    logic       err_q,    err_d;
    logic [7:0] frame;

    assign frame = {seg_nib, lo_q};

    // Next-state: error beats frame completion; digit-1 only counts after a digit 0
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        cand_d   = cand_q;
        match_d  = match_q;
        data_d   = data_q;
        locked_d = locked_q;
        stable_d = stable_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (sample_err) begin
            err_d    = 1'b1;
            state_d  = ST_IDLE;
            match_d  = 4'd0;
            stable_d = 1'b0;
        end else if (sample && is_d0) begin
            lo_d    = seg_nib;
            state_d = ST_GOT_LO;
        end else if (sample && is_d1 && (state_q == ST_GOT_LO)) begin
            state_d = ST_IDLE;

            // Track how many identical frames have been seen in a row
            if (frame == cand_q) begin
                if (match_q < CONFIRM_N) begin
                    match_d = match_q + 4'd1;
                end
            end else begin
                cand_d  = frame;
                match_d = 4'd1;
            end

            // Confirmed: reload only on a new value (or the first lock)
            if (match_d == CONFIRM_N) begin
                if ((cand_d != data_q) || !locked_q) begin
                    data_d   = cand_d;
                    valid_d  = 1'b1;
                    locked_d = 1'b1;
                end
                stable_d = 1'b1;
            end else if (frame != data_q) begin
                stable_d = 1'b0;
            end
        end
    end

    // Register FSM, candidate tracking and all outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lo_q     <= 4'h0;
            cand_q   <= 8'h00;
            match_q  <= 4'd0;
            data_q   <= 8'h00;
            locked_q <= 1'b0;
            stable_q <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            data_q   <= data_d;
            locked_q <= locked_d;
            stable_q <= stable_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign bus.data        = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.data_stable = stable_q;
    assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: two instances (confirm depth 2 and 1) share a
// randomised scan-bus stimulus. A sample-level model predicts every output
// event (data_valid, frame_err, data_stable change) and the cycle it lands
// on; a monitor pops and compares as the DUTs present them.
module tb_seg_scan_decoder;

    localparam int S = 16;

    localparam logic [7:0] SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] wei_drv  = 4'hF;
    logic [7:0] duan_drv = 8'hFF;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_scan_decoder_if bus_a ();
    seg_scan_decoder_if bus_b ();

    assign bus_a.sm_wei  = wei_drv;
    assign bus_a.sm_duan = duan_drv;
    assign bus_b.sm_wei  = wei_drv;
    assign bus_b.sm_duan = duan_drv;

    seg_scan_decoder #(.SETTLE_CYCLES(S), .CONFIRM_SCANS(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    seg_scan_decoder #(.SETTLE_CYCLES(S), .CONFIRM_SCANS(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        int         cyc;
        logic       v;
        logic       e;
        logic [7:0] d;
        logic       s;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    int nchk = 0;
    int nerr = 0;

    // ---------------- reference model (one sample at a time) ----------------
    int         conf [2] = '{2, 1};
    bit         m_have_lo [2];
    logic [3:0] m_lo [2];
    logic [7:0] m_cand [2];
    int         m_match [2];
    logic [7:0] m_data [2];
    bit         m_locked [2];
    bit         m_stable [2];

    function automatic int seg_lookup(input logic [7:0] b);
        for (int i = 0; i < 16; i++) if (SEG[i] == b) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_have_lo[k] = 0; m_lo[k] = 0; m_cand[k] = 0; m_match[k] = 0;
            m_data[k] = 0; m_locked[k] = 0; m_stable[k] = 0;
        end
    endtask

    task automatic model_sample(input int k, input logic [3:0] w,
                                input logic [7:0] d, input int ocyc);
        int nib;
        bit err;
        bit pv;
        bit ps;
        logic [7:0] fr;
        ev_t x;
        err = 0; pv = 0;
        ps  = m_stable[k];
        nib = seg_lookup(d);
        if (w == 4'b1110 || w == 4'b1101) err = (nib < 0);
        else err = !(w == 4'b1011 || w == 4'b0111 || w == 4'b1111);
        if (err) begin
            m_have_lo[k] = 0; m_match[k] = 0; m_stable[k] = 0;
        end else if (w == 4'b1110) begin
            m_lo[k] = nib[3:0]; m_have_lo[k] = 1;
        end else if (w == 4'b1101 && m_have_lo[k]) begin
            m_have_lo[k] = 0;
            fr = {nib[3:0], m_lo[k]};
            if (fr == m_cand[k]) m_match[k] = (m_match[k] + 1 > conf[k]) ? conf[k] : m_match[k] + 1;
            else begin m_cand[k] = fr; m_match[k] = 1; end
            if (m_match[k] == conf[k]) begin
                if (m_cand[k] != m_data[k] || !m_locked[k]) begin
                    m_data[k] = m_cand[k]; m_locked[k] = 1; pv = 1;
                end
                m_stable[k] = 1;
            end else if (fr != m_data[k]) begin
                m_stable[k] = 0;
            end
        end
        if (err || pv || (m_stable[k] != ps)) begin
            x.cyc = ocyc; x.v = pv; x.e = err; x.d = m_data[k]; x.s = m_stable[k];
            if (k == 0) qa.push_back(x); else qb.push_back(x);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    logic [3:0] last_w = 4'hF;

    function automatic int rl();
        return int'($urandom_range(S, S + 24));
    endfunction

    // Hold one select/segment pair for len cycles (starts just after a posedge)
    task automatic drive(input logic [3:0] w, input logic [7:0] d, input int len);
        if (w == last_w && w != 4'hF) begin
            wei_drv = 4'hF; duan_drv = 8'hFF;
            repeat (2) @(posedge clk);
            #1;
        end
        wei_drv = w; duan_drv = d; last_w = w;
        if (len >= S) begin
            // pins -> 2 sync flops -> S-1 dwell cycles -> registered output
            for (int k = 0; k < 2; k++) model_sample(k, w, d, cyc + S + 2);
        end
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic frames(input logic [7:0] v, input int n, input int len);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = v[3:0]; hi = v[7:4];
        for (int i = 0; i < n; i++) begin
            drive(4'b1110, SEG[lo], (len > 0) ? len : rl());
            drive(4'b1101, SEG[hi], (len > 0) ? len : rl());
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic do_reset();
        wei_drv = 4'hF; duan_drv = 8'hFF; last_w = 4'hF;
        repeat (4) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_data_a",   bus_a.data, 8'h00);
        chk("rst_valid_a",  {7'd0, bus_a.data_valid}, 8'h00);
        chk("rst_stable_a", {7'd0, bus_a.data_stable}, 8'h00);
        chk("rst_err_a",    {7'd0, bus_a.frame_err}, 8'h00);
        chk("rst_data_b",   bus_b.data, 8'h00);
        chk("rst_valid_b",  {7'd0, bus_b.data_valid}, 8'h00);
        chk("rst_stable_b", {7'd0, bus_b.data_stable}, 8'h00);
        chk("rst_err_b",    {7'd0, bus_b.frame_err}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        $display("reset released at cycle %0d", cyc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit last_s [2];

    task automatic check_out(input int k, input logic v, input logic e,
                             input logic [7:0] d, input logic s);
        ev_t x;
        nchk++;
        if ((k == 0 && qa.size() == 0) || (k == 1 && qb.size() == 0)) begin
            nerr++;
            $display("FAIL unexpected_event dut%0d cyc=%0d got v=%b e=%b data=%h stable=%b want none",
                     k, cyc, v, e, d, s);
            return;
        end
        if (k == 0) x = qa.pop_front(); else x = qb.pop_front();
        if (x.cyc != cyc || x.v !== v || x.e !== e || x.d !== d || x.s !== s) begin
            nerr++;
            $display("FAIL event dut%0d: got cyc=%0d v=%b e=%b data=%h stable=%b want cyc=%0d v=%b e=%b data=%h stable=%b",
                     k, cyc, v, e, d, s, x.cyc, x.v, x.e, x.d, x.s);
        end else begin
            $display("ok dut%0d cyc=%0d valid=%b err=%b data=%h stable=%b", k, cyc, v, e, d, s);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last_s[0] = 1'b0;
            last_s[1] = 1'b0;
        end else begin
            if (bus_a.data_valid || bus_a.frame_err || (bus_a.data_stable != last_s[0]))
                check_out(0, bus_a.data_valid, bus_a.frame_err, bus_a.data, bus_a.data_stable);
            last_s[0] = bus_a.data_stable;
            if (bus_b.data_valid || bus_b.frame_err || (bus_b.data_stable != last_s[1]))
                check_out(1, bus_b.data_valid, bus_b.frame_err, bus_b.data, bus_b.data_stable);
            last_s[1] = bus_b.data_stable;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] cur;
        logic [7:0] b;
        logic [3:0] w;
        int         r;

        model_clear();
        do_reset();
        drive(4'hF, 8'hFF, 5);

        // Lock on A5, then hold it (no further pulses)
        frames(8'hA5, 2, 200);
        frames(8'hA5, 4, 0);
        // Switch to 3C
        frames(8'h3C, 3, 0);
        // Bad segment bytes on digit 0, then re-lock
        drive(4'b1110, 8'hFF, rl());
        drive(4'b1101, SEG[3], rl());
        drive(4'b1110, 8'h40, rl());
        drive(4'b1101, SEG[3], rl());
        frames(8'h3C, 2, 0);
        // Illegal select held long, then a too-short digit-0 dwell
        drive(4'b1100, SEG[0], 200);
        frames(8'h3C, 2, 0);
        drive(4'b1110, SEG[9], 5);
        drive(4'b1101, SEG[9], rl());
        frames(8'h3C, 1, 0);
        // 00 then FF
        frames(8'h00, 2, 0);
        frames(8'hFF, 2, 0);
        // Reset after the digit-0 sample of a frame
        drive(4'b1110, SEG[4], rl());
        do_reset();
        drive(4'hF, 8'hFF, 5);
        frames(8'h5A, 3, 0);

        // Randomised traffic
        cur = 8'h5A;
        for (int it = 0; it < 60; it++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3: begin
                    if ($urandom_range(0, 2) == 0) cur = 8'($urandom);
                    frames(cur, int'($urandom_range(1, 3)), 0);
                end
                4: frames(cur, 1, 0);
                5: begin
                    drive(4'b1110, SEG[$urandom_range(0, 15)], rl());
                    frames(cur, 1, 0);
                end
                6: begin
                    do b = 8'($urandom); while (seg_lookup(b) >= 0);
                    drive(($urandom_range(0, 1) == 0) ? 4'b1110 : 4'b1101, b, rl());
                end
                7: begin
                    do w = 4'($urandom);
                    while (w == 4'b1110 || w == 4'b1101 || w == 4'b1011 ||
                           w == 4'b0111 || w == 4'b1111);
                    drive(w, 8'($urandom), rl());
                end
                8: begin
                    case ($urandom_range(0, 2))
                        0: w = 4'b1011;
                        1: w = 4'b0111;
                        default: w = 4'b1111;
                    endcase
                    drive(w, 8'($urandom), rl());
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: w = 4'b1110;
                        1: w = 4'b1101;
                        2: w = 4'b0011;
                        default: w = 4'b1100;
                    endcase
                    drive(w, 8'($urandom), int'($urandom_range(2, S - 1)));
                end
            endcase
        end

        // Drain and final checks
        drive(4'hF, 8'hFF, S + 8);
        @(negedge clk);
        chk("final_data_a", bus_a.data, m_data[0]);
        chk("final_data_b", bus_b.data, m_data[1]);
        nchk++;
        if (qa.size() != 0) begin
            nerr++;
            $display("FAIL pending_a: got %0d missing events want 0", qa.size());
        end
        nchk++;
        if (qb.size() != 0) begin
            nerr++;
            $display("FAIL pending_b: got %0d missing events want 0", qb.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
